// File: rtl/md5_pkg.sv
// Shared constants and types for the MD5 front end.
// Block geometry, padding byte and the padder state encoding.
package md5_pkg;

  localparam int MD5_BLOCK_BITS = 512;
  localparam int MD5_LEN_BITS = 64;
  localparam logic [7:0] MD5_PAD_BYTE = 8'h80;
  localparam int MD5_MAX_SINGLE_BYTES = 55;
  localparam int MD5_BUF_BYTES =
    (MD5_BLOCK_BITS - MD5_LEN_BITS) / 8;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_PAD,
    ST_HOLD
  } pad_state_e;

endpackage

// File: rtl/md5_msg_padder_if.sv
// Nibble input stream and padded block output of the MD5 padder.
// slave is the padder's view, master the environment's view.
interface md5_msg_padder_if;
  import md5_pkg::*;

  logic [3:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tlast;
  logic       s_axis_tready;

  logic [MD5_BLOCK_BITS-1:0] m_blk_tdata;
  logic                      m_blk_tvalid;
  logic                      m_blk_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid,
    input  s_axis_tlast, m_blk_tready,
    output s_axis_tready, m_blk_tdata,
    output m_blk_tvalid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid,
    output s_axis_tlast, m_blk_tready,
    input  s_axis_tready, m_blk_tdata,
    input  m_blk_tvalid
  );

endinterface

// File: rtl/md5_nibble_packer.sv
// Packs high/low nibble pairs into bytes; a tlast on a high
// nibble closes the byte with a zero low nibble.
module md5_nibble_packer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       fire,
  input  logic [3:0] nib,
  input  logic       last,
  output logic [7:0] byte_o,
  output logic       strobe
);

  // phase_q = 1 while waiting for the low nibble
  logic       phase_q, phase_d;
  logic [3:0] hi_q, hi_d;

  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    strobe  = fire & (phase_q | last);
    byte_o  = phase_q ? {hi_q, nib} : {nib, 4'h0};
    if (clr) begin
      phase_d = 1'b0;
      hi_d    = '0;
    end else if (fire) begin
      if (phase_q) begin
        phase_d = 1'b0;
      end else begin
        hi_d    = nib;
        phase_d = ~last;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: rtl/md5_msg_padder.sv
// Collects a nibble-streamed password and emits one MD5-padded
// 512-bit block; oversized messages are truncated and flagged.
module md5_msg_padder
  import md5_pkg::*;
#(
  parameter int MAX_BYTES = MD5_MAX_SINGLE_BYTES
) (
  input  logic               clk,
  input  logic               reset,
  md5_msg_padder_if.slave    bus,
  output logic [5:0]         byte_count,
  output logic               overflow_err
);

  pad_state_e state_q, state_d;
  logic [7:0] buf_q [MD5_BUF_BYTES];
  logic [7:0] buf_d [MD5_BUF_BYTES];
  logic [MD5_LEN_BITS-1:0] len_q, len_d;
  logic [5:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic       last_q, last_d;
  logic       valid_q, valid_d;
  logic       clr;

  logic       rdy, full, fire, pk_fire, pk_strobe;
  logic [7:0] pk_byte;
  logic [MD5_BLOCK_BITS-1:0] blk;

  // last_q holds off input for the cycle before PAD
  assign rdy     = (state_q == ST_COLLECT) & ~last_q & ~reset;
  assign full    = (cnt_q == 6'(MAX_BYTES));
  assign fire    = bus.s_axis_tvalid & rdy;
  assign pk_fire = fire & ~full;

  md5_nibble_packer u_pack (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .fire   (pk_fire),
    .nib    (bus.s_axis_tdata),
    .last   (bus.s_axis_tlast),
    .byte_o (pk_byte),
    .strobe (pk_strobe)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    last_d  = last_q;
    valid_d = valid_q;
    clr     = 1'b0;
    unique case (state_q)
      ST_COLLECT: begin
        if (pk_strobe) begin
          buf_d[cnt_q] = pk_byte;
          cnt_d        = cnt_q + 6'd1;
        end
        if (fire & full) ovf_d = 1'b1;
        if (fire & bus.s_axis_tlast) last_d = 1'b1;
        if (last_q) begin
          last_d  = 1'b0;
          state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        for (int i = 0; i < MD5_BUF_BYTES; i++) begin
          if (i == int'(cnt_q))
            buf_d[i] = MD5_PAD_BYTE;
          else if (i > int'(cnt_q))
            buf_d[i] = '0;
        end
        len_d   = MD5_LEN_BITS'({cnt_q, 3'b000});
        valid_d = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.m_blk_tready) begin
          clr     = 1'b1;
          buf_d   = '{default: '0};
          len_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          valid_d = 1'b0;
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_COLLECT;
      buf_q   <= '{default: '0};
      len_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    blk = '0;
    for (int k = 0; k < MD5_BUF_BYTES; k++)
      blk[8*k +: 8] = buf_q[k];
    blk[MD5_BLOCK_BITS-1 -: MD5_LEN_BITS] = len_q;
  end

  assign bus.s_axis_tready = rdy;
  assign bus.m_blk_tvalid  = valid_q;
  assign bus.m_blk_tdata   = blk;
  assign byte_count        = cnt_q;
  assign overflow_err      = ovf_q;

endmodule

// File: tb/tb_md5_msg_padder.sv
// Randomised bench for md5_msg_padder with a queue-based padding
// model; directed cases pin the model with literal blocks.
module tb_md5_msg_padder;
  import md5_pkg::*;

  typedef logic [3:0] nib_q_t[$];
  typedef struct packed {
    logic [511:0] blk;
    logic [5:0]   cnt;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] byte_count;
  logic overflow_err;

  always #5 clk = ~clk;

  md5_msg_padder_if bus ();

  md5_msg_padder #(.MAX_BYTES(55)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .byte_count   (byte_count),
    .overflow_err (overflow_err)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int tlast_edge = 0;
  int rdy_mode = 1;
  int hs = 0;
  bit prev_v = 1'b0;
  exp_t exp_q[$];
  exp_t cur;

  function automatic void cmp(input string nm,
                              input logic [511:0] act,
                              input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endfunction

  function automatic exp_t model(input nib_q_t n);
    exp_t e;
    int nn;
    int L;
    logic [7:0] b;
    nn = n.size();
    L = (nn + 1) / 2;
    if (L > 55) L = 55;
    e.blk = '0;
    for (int i = 0; i < L; i++) begin
      b[7:4] = n[2*i];
      b[3:0] = (2*i + 1 < nn) ? n[2*i+1] : 4'h0;
      e.blk[8*i +: 8] = b;
    end
    e.blk[8*L +: 8] = 8'h80;
    e.blk[511:448] = 64'(L * 8);
    e.cnt = 6'(L);
    e.ovf = (nn > 110);
    return e;
  endfunction

  function automatic nib_q_t str2nib(input string s);
    nib_q_t q;
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      q.push_back(c[7:4]);
      q.push_back(c[3:0]);
    end
    return q;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) bus.m_blk_tready = 1'b1;
    else if (rdy_mode == 2) bus.m_blk_tready = 1'b0;
    else bus.m_blk_tready = 1'($urandom_range(0, 1));
  end

  // Output checker: block contents, latency, hold and release.
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
      hs = 0;
    end else begin
      if (hs == 2) begin
        cmp("s_ready_after_accept", bus.s_axis_tready, 1);
        hs = 0;
      end
      if (hs == 1) begin
        cmp("valid_drop", bus.m_blk_tvalid, 0);
        cmp("count_clear", byte_count, 0);
        cmp("ovf_clear", overflow_err, 0);
        hs = 2;
      end else if (bus.m_blk_tvalid) begin
        if (!prev_v) begin
          if (exp_q.size() == 0) begin
            cmp("unexpected_blk", 1, 0);
            cur = '0;
          end else begin
            cur = exp_q.pop_front();
            cmp("blk_latency", 512'(cyc - tlast_edge), 2);
          end
        end
        cmp("blk_data", bus.m_blk_tdata, cur.blk);
        cmp("blk_count", byte_count, cur.cnt);
        cmp("blk_ovf", overflow_err, cur.ovf);
        cmp("s_ready_hold", bus.s_axis_tready, 0);
        if (bus.m_blk_tready) hs = 1;
      end
      prev_v = bus.m_blk_tvalid;
    end
  end

  task automatic send(input nib_q_t n, input bit with_last);
    int k = 0;
    int guard = 0;
    bit acc;
    bit just = 1'b0;
    bit lst;
    while (k < n.size() && guard < 5000) begin
      @(negedge clk);
      if (just) begin
        cmp("run_count", byte_count, (k > 110) ? 55 : k / 2);
        cmp("run_ovf", overflow_err, k > 110);
        just = 1'b0;
      end
      guard++;
      if ($urandom_range(0, 3) == 0) begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata = 4'($urandom);
        bus.s_axis_tlast = 1'($urandom);
        continue;
      end
      lst = with_last && (k == n.size() - 1);
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata = n[k];
      bus.s_axis_tlast = lst;
      #1 acc = bus.s_axis_tready;
      @(posedge clk);
      if (acc) begin
        k++;
        just = 1'b1;
        if (lst) begin
          #1 tlast_edge = cyc;
          exp_q.push_back(model(n));
        end
      end
    end
    if (guard >= 5000) cmp("send_timeout", 1, 0);
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
    if (just) begin
      cmp("end_count", byte_count,
          (k > 110) ? 55 : (k + 32'(with_last)) / 2);
      cmp("end_ovf", overflow_err, k > 110);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || hs != 0 || bus.m_blk_tvalid)
           && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) cmp("drain_timeout", 1, 0);
  endtask

  initial begin
    nib_q_t q;
    exp_t e;
    int t;
    reset = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata = '0;
    bus.s_axis_tlast = 1'b0;
    bus.m_blk_tready = 1'b0;
    #1;
    cmp("rst_s_ready", bus.s_axis_tready, 0);
    cmp("rst_valid", bus.m_blk_tvalid, 0);
    cmp("rst_data", bus.m_blk_tdata, 0);
    cmp("rst_count", byte_count, 0);
    cmp("rst_ovf", overflow_err, 0);
    #22 reset = 1'b0;
    @(negedge clk);
    cmp("idle_s_ready", bus.s_axis_tready, 1);

    e = model(str2nib("abc"));
    cmp("model_abc", e.blk, {64'h18, 416'h0, 32'h80636261});
    q = {4'hA};
    e = model(q);
    cmp("model_a", e.blk, {64'h8, 432'h0, 16'h80A0});
    q = {};
    for (int i = 0; i < 114; i++) q.push_back(4'h3);
    e = model(q);
    cmp("model_ovf", e.blk, {64'h1B8, 8'h80, {55{8'h33}}});
    cmp("model_ovf_flag", e.ovf, 1);

    // "abc" under backpressure
    rdy_mode = 2;
    send(str2nib("abc"), 1'b1);
    t = 0;
    while (!bus.m_blk_tvalid && t < 10) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    cmp("bp_valid_held", bus.m_blk_tvalid, 1);
    rdy_mode = 1;
    drain();

    q = {4'hA};
    send(q, 1'b1);
    drain();

    q = {};
    for (int i = 0; i < 114; i++) q.push_back(4'h3);
    send(q, 1'b1);
    drain();

    // asynchronous reset mid-collection
    q = {4'h6, 4'h1, 4'h6};
    send(q, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    cmp("mid_rst_s_ready", bus.s_axis_tready, 0);
    cmp("mid_rst_valid", bus.m_blk_tvalid, 0);
    cmp("mid_rst_data", bus.m_blk_tdata, 0);
    cmp("mid_rst_count", byte_count, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    send(str2nib("abc"), 1'b1);
    drain();

    send(str2nib("1"), 1'b1);
    send(str2nib("12"), 1'b1);
    drain();

    rdy_mode = 0;
    for (int p = 0; p < 25; p++) begin
      q = {};
      t = (p % 5 == 0) ? $urandom_range(100, 120)
                       : $urandom_range(1, 40);
      for (int i = 0; i < t; i++) q.push_back(4'($urandom));
      send(q, 1'b1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
